// File: rtl/i2c_cfg_slave.sv
// Write-only I2C configuration responder: START, addr+W, sub-address, data bytes, STOP.
// Define I2C_READ_EN to also answer addr+R frames from iRD_DATA at oRD_ADDR.
module i2c_cfg_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h1A,
  parameter bit         SUB_AUTOINC = 1'b1
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic       oWR_EN,
  output logic [7:0] oWR_ADDR,
  output logic [7:0] oWR_DATA,
  output logic       oBUSY,
  output logic [7:0] oRD_ADDR,
  input  logic [7:0] iRD_DATA
);

  localparam int unsigned SYNC_W = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    SUB,
    SUB_ACK,
    DATA,
    DATA_ACK,
    IGNORE,
    TX,
    TX_ACK
  } state_t;

  state_t              state_q, state_d;
  logic [SYNC_W-1:0]   scl_sync_q, scl_sync_d;
  logic [SYNC_W-1:0]   sda_sync_q, sda_sync_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic [BYTE_W-1:0]   sub_q, sub_d;
  logic [BYTE_W-1:0]   wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0]   wr_data_q, wr_data_d;
  logic                ack_ph_q, ack_ph_d;
  logic                sda_oe_q, sda_oe_d;
  logic                wr_en_q, wr_en_d;
  logic                busy_q, busy_d;

  logic                scl_cur, scl_prv, sda_cur, sda_prv;
  logic                scl_rise, scl_fall, start_det, stop_det;
  logic                addr_hit;
  logic [BYTE_W-1:0]   shifted;

  // Open-drain data line: pull low or release, never drive high
  assign I2C_SDAT = sda_oe_q ? 1'b0 : 1'bz;

  // Bit [1] is the synchronized level, bit [2] its history
  assign scl_cur   = scl_sync_q[1];
  assign scl_prv   = scl_sync_q[2];
  assign sda_cur   = sda_sync_q[1];
  assign sda_prv   = sda_sync_q[2];
  assign scl_rise  = scl_cur & ~scl_prv;
  assign scl_fall  = ~scl_cur & scl_prv;
  assign start_det = scl_cur & scl_prv & sda_prv & ~sda_cur;
  assign stop_det  = scl_cur & scl_prv & ~sda_prv & sda_cur;
  assign shifted   = {shift_q[BYTE_W-2:0], sda_cur};

`ifdef I2C_READ_EN
  assign addr_hit = (shifted[7:1] == SLAVE_ADDR);
`else
  assign addr_hit = (shifted[7:1] == SLAVE_ADDR) && !shifted[0];
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= IDLE;
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      sub_q      <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      ack_ph_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      sub_q      <= sub_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ack_ph_q   <= ack_ph_d;
      sda_oe_q   <= sda_oe_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    scl_sync_d = {scl_sync_q[SYNC_W-2:0], I2C_SCLK};
    sda_sync_d = {sda_sync_q[SYNC_W-2:0], I2C_SDAT};
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sub_d      = sub_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    ack_ph_d   = ack_ph_q;
    sda_oe_d   = sda_oe_q;
    wr_en_d    = 1'b0;
    busy_d     = busy_q;

    if (stop_det) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
      ack_ph_d  = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
      ack_ph_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;

        ADDR: begin
          if (scl_rise) begin
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(7)) begin
              state_d  = ADDR_ACK;
              ack_ph_d = 1'b0;
              busy_d   = addr_hit;
            end
          end
        end

        // busy_q doubles as the address-match flag while acknowledging
        ADDR_ACK: begin
          if (!busy_q) begin
            state_d = IGNORE;
          end else if (scl_fall) begin
            if (!ack_ph_q) begin
              sda_oe_d = 1'b1;
              ack_ph_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              ack_ph_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = SUB;
`ifdef I2C_READ_EN
              if (shift_q[0]) begin
                state_d  = TX;
                shift_d  = {iRD_DATA[BYTE_W-2:0], 1'b0};
                sda_oe_d = ~iRD_DATA[BYTE_W-1];
              end
`endif
            end
          end
        end

        SUB: begin
          if (scl_rise) begin
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(7)) begin
              sub_d    = shifted;
              state_d  = SUB_ACK;
              ack_ph_d = 1'b0;
            end
          end
        end

        SUB_ACK, DATA_ACK: begin
          if (scl_fall) begin
            if (!ack_ph_q) begin
              sda_oe_d = 1'b1;
              ack_ph_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              ack_ph_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = DATA;
            end
          end
        end

        // Strobe issued the cycle after the 8th bit is sampled
        DATA: begin
          if (scl_rise) begin
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(7)) begin
              wr_en_d   = 1'b1;
              wr_addr_d = sub_q;
              wr_data_d = shifted;
              if (SUB_AUTOINC) sub_d = sub_q + BYTE_W'(1);
              state_d   = DATA_ACK;
              ack_ph_d  = 1'b0;
            end
          end
        end

        IGNORE: sda_oe_d = 1'b0;

`ifdef I2C_READ_EN
        TX: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else if (scl_fall) begin
            if (bit_cnt_q == CNT_W'(8)) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = TX_ACK;
            end else begin
              sda_oe_d = ~shift_q[BYTE_W-1];
              shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
            end
          end
        end

        // A NACK leaves at once, so any falling edge here follows an ACK
        TX_ACK: begin
          if (scl_rise) begin
            if (sda_cur) state_d = IGNORE;
            else if (SUB_AUTOINC) sub_d = sub_q + BYTE_W'(1);
          end else if (scl_fall) begin
            shift_d   = {iRD_DATA[BYTE_W-2:0], 1'b0};
            sda_oe_d  = ~iRD_DATA[BYTE_W-1];
            bit_cnt_d = '0;
            state_d   = TX;
          end
        end
`endif

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign oWR_EN   = wr_en_q;
  assign oWR_ADDR = wr_addr_q;
  assign oWR_DATA = wr_data_q;
  assign oBUSY    = busy_q;

`ifdef I2C_READ_EN
  assign oRD_ADDR = sub_q;
`else
  logic unused_rd_data;
  assign unused_rd_data = ^iRD_DATA;
  assign oRD_ADDR       = 8'h00;
`endif

endmodule
